lsu_ctrl: RTL

Load/store unit sitting between the MIPS execute stage and data_mem; acts as the initiator on data_mem's read_en/write_en/addr/data_in/data_out interface. Accepts one load or store request per transaction and issues the word-wide memory accesses data_mem supports. Performs byte/halfword lane extraction with sign/zero extension. Implements sub-word stores as read-modify-write, because data_mem writes whole words only. Returns a single-cycle response with data or an error.

---
 rtl/lsu_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the execute stage and data_mem.
// Issues word-wide reads and writes, extracts byte/halfword lanes
// (big-endian) with sign or zero extension, and performs sub-word stores
// as read-modify-write. Optional macro LSU_PERF_CNT_EN adds saturating
// performance counters; without it the perf_* ports are tied to 0.
//
// state  | meaning
// IDLE   | ready for a request; errors go straight to RESP
// LOAD   | word read, lane extracted into resp_rdata
// RMW_RD | word read, store lane merged into write buffer
// WRITE  | word write to data_mem
// RESP   | one-cycle response pulse
module lsu_ctrl #(
    parameter int DATA_MEM_SIZE = 1024,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [31:0]          resp_rdata,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic [CNT_WIDTH-1:0] perf_loads,
    output logic [CNT_WIDTH-1:0] perf_stores,
    output logic [CNT_WIDTH-1:0] perf_errs
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [32:0] MEM_LIMIT = 33'(DATA_MEM_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [2:0]  req_size;
    logic [32:0] req_end;
    logic        req_misalign;
    logic        req_err;
    logic        req_is_load;
    logic        op_q_is_store;
    logic [31:0] rd_shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merge_mask;
    logic [31:0] merge_data;
    logic [31:0] merged;

    // Access size, alignment and range check for the incoming request
    always_comb begin
        req_size     = 3'd4;
        req_misalign = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: req_size = 3'd1;
            OP_LH, OP_LHU, OP_SH: begin
                req_size     = 3'd2;
                req_misalign = req_addr[0];
            end
            default: begin
                req_size     = 3'd4;
                req_misalign = (req_addr[1:0] != 2'b00);
            end
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap into range
    assign req_end       = {1'b0, req_addr} + {30'd0, req_size};
    assign req_err       = req_misalign || (req_end > MEM_LIMIT);
    assign req_is_load   = (req_op <= OP_LHU);
    assign op_q_is_store = (op_q >= OP_SB);

    // Lane extraction and store-lane merge on the read word (big-endian lanes)
    always_comb begin
        rd_shifted = mem_rdata >> {~addr_q[1:0], 3'b000};
        rd_byte    = rd_shifted[7:0];
        rd_half    = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (op_q)
            OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_val = {24'd0, rd_byte};
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_val = {16'd0, rd_half};
            default: load_val = mem_rdata;
        endcase
        if (op_q == OP_SB) begin
            merge_mask = 32'h0000_00FF << {~addr_q[1:0], 3'b000};
            merge_data = {4{wdata_q[7:0]}};
        end else begin
            merge_mask = addr_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
            merge_data = {2{wdata_q[15:0]}};
        end
        merged = (mem_rdata & ~merge_mask) | (merge_data & merge_mask);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and memory-side strobes, decoded from the current state
    always_comb begin
        state_nxt    = state;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_wdata    = 32'd0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_nxt = ST_RESP;
                    end else if (req_is_load) begin
                        state_nxt = ST_LOAD;
                    end else if (req_op == OP_SW) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                mem_read_en = 1'b1;
                state_nxt   = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read_en = 1'b1;
                state_nxt   = ST_WRITE;
            end
            ST_WRITE: begin
                mem_write_en = 1'b1;
                mem_wdata    = (op_q == OP_SW) ? wdata_q : wbuf_q;
                state_nxt    = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, write buffer and response registers; the response
    // registers only change on the edge entering RESP so they hold between
    // responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wbuf_q       <= 32'd0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end
                    end
                end
                ST_LOAD: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_val;
                end
                ST_RMW_RD: begin
                    wbuf_q <= merged;
                end
                ST_WRITE: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};

`ifdef LSU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] loads_q, stores_q, errs_q;

    // Saturating counters, bumped once per response by outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else if (state == ST_RESP) begin
            if (resp_err_q) begin
                if (errs_q != '1) errs_q <= errs_q + 1'b1;
            end else if (op_q_is_store) begin
                if (stores_q != '1) stores_q <= stores_q + 1'b1;
            end else begin
                if (loads_q != '1) loads_q <= loads_q + 1'b1;
            end
        end
    end

    assign perf_loads  = loads_q;
    assign perf_stores = stores_q;
    assign perf_errs   = errs_q;
`else
    logic unused_store_flag;
    assign unused_store_flag = op_q_is_store;
    assign perf_loads        = '0;
    assign perf_stores       = '0;
    assign perf_errs         = '0;
`endif

endmodule
